// File: rtl/sensor_resp_assembler.sv
// Receive-side framing stage: collects a 4-byte sensor reply {addr, data_hi, data_lo, chk}
// from UART byte strobes, validates address/checksum, and flags inter-byte timeouts.
module sensor_resp_assembler #(
    parameter int TIMEOUT_CYCLES = 500000,
    parameter int CNT_W          = 20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  exp_addr,
    input  logic        rx_DV,
    input  logic [7:0]  rx_Byte,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [1:0]  error
);

    typedef enum logic [2:0] {IDLE, W_ADDR, W_HI, W_LO, W_CHK, FIN} state_t;

    // Expiry is decided one cycle early so the registered done lands exactly
    // TIMEOUT_CYCLES cycles after the last accepted byte or start.
    localparam logic [CNT_W-1:0] EXPIRY  = CNT_W'(TIMEOUT_CYCLES - 2);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t             state_reg, state_next;
    logic [7:0]         exp_reg, exp_next;
    logic [7:0]         sum_reg, sum_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic [31:0]        result_reg, result_next;
    logic [1:0]         error_reg, error_next;
    logic [2:0]         load;
    logic [23:0]        frame_bits;
    logic               fin_go;
    logic [1:0]         fin_err;
    logic [31:0]        fin_res;

    // One byte register per stored frame position: addr, data_hi, data_lo.
    for (genvar gi = 0; gi < 3; gi++) begin : g_frame
        logic [7:0] byte_reg;
        always_ff @(posedge clock) begin
            if (reset) begin
                byte_reg <= '0;
            end else if (load[gi]) begin
                byte_reg <= rx_Byte;
            end
        end
        assign frame_bits[(2-gi)*8 +: 8] = byte_reg;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= IDLE;
            exp_reg    <= '0;
            sum_reg    <= '0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            result_reg <= '0;
            error_reg  <= 2'b00;
        end else begin
            state_reg  <= state_next;
            exp_reg    <= exp_next;
            sum_reg    <= sum_next;
            cnt_reg    <= cnt_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
            result_reg <= result_next;
            error_reg  <= error_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        exp_next    = exp_reg;
        sum_next    = sum_reg;
        cnt_next    = cnt_reg;
        busy_next   = busy_reg;
        done_next   = 1'b0;
        result_next = result_reg;
        error_next  = error_reg;
        load        = 3'b000;
        fin_go      = 1'b0;
        fin_err     = 2'b00;
        fin_res     = 32'h0000_0000;

        case (state_reg)
            IDLE: begin
                // A byte coinciding with start is dropped: rx_DV is not looked at here.
                if (start) begin
                    exp_next   = exp_addr;
                    cnt_next   = '0;
                    sum_next   = '0;
                    busy_next  = 1'b1;
                    state_next = W_ADDR;
                end
            end
            W_ADDR, W_HI, W_LO, W_CHK: begin
                if (rx_DV) begin
                    cnt_next = '0;
                    case (state_reg)
                        W_ADDR: begin
                            if (rx_Byte == exp_reg) begin
                                load[0]    = 1'b1;
                                sum_next   = rx_Byte;
                                state_next = W_HI;
                            end else begin
                                fin_go  = 1'b1;
                                fin_err = 2'b10;
                            end
                        end
                        W_HI: begin
                            load[1]    = 1'b1;
                            sum_next   = sum_reg + rx_Byte;
                            state_next = W_LO;
                        end
                        W_LO: begin
                            load[2]    = 1'b1;
                            sum_next   = sum_reg + rx_Byte;
                            state_next = W_CHK;
                        end
                        default: begin
                            fin_go = 1'b1;
                            if (rx_Byte == sum_reg) begin
                                fin_err = 2'b00;
                                fin_res = {frame_bits, rx_Byte};
                            end else begin
                                fin_err = 2'b11;
                            end
                        end
                    endcase
                end else if (cnt_reg == EXPIRY) begin
                    fin_go  = 1'b1;
                    fin_err = 2'b01;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase

        if (fin_go) begin
            state_next  = FIN;
            busy_next   = 1'b0;
            done_next   = 1'b1;
            result_next = fin_res;
            error_next  = fin_err;
        end
    end

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign result = result_reg;
    assign error  = error_reg;

endmodule

// File: tb/tb_sensor_resp_assembler.sv
// Bench for sensor_resp_assembler: table of frames plus hand-written corner sequences,
// with a done-pulse scoreboard checking result, error, latency and busy.
module tb_sensor_resp_assembler;

    localparam int T = 100;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  exp_addr = '0;
    logic        rx_DV = 1'b0;
    logic [7:0]  rx_Byte = '0;
    logic        busy, done;
    logic [31:0] result;
    logic [1:0]  error;

    sensor_resp_assembler #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
        .clock(clock), .reset(reset), .start(start), .exp_addr(exp_addr),
        .rx_DV(rx_DV), .rx_Byte(rx_Byte), .busy(busy), .done(done),
        .result(result), .error(error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] res;
        logic [1:0]  err;
        int          neg;
    } exp_t;

    typedef struct {
        logic [7:0]       ea;
        logic [3:0][7:0]  b;
        int               trig;
        logic [31:0]      res;
        logic [1:0]       err;
    } vec_t;

    exp_t q[$];
    vec_t vecs[6];
    int   checks = 0;
    int   errors = 0;
    int   neg_cnt = 0;
    int   snap = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Scoreboard: every done pulse is matched against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            neg_cnt++;
            if (done === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done=1 at negedge %0d with no frame pending", neg_cnt);
                end else begin
                    e = q.pop_front();
                    check("result", result, e.res);
                    check("error", {30'd0, error}, {30'd0, e.err});
                    check("done_latency", neg_cnt, e.neg);
                    check("busy_in_done", {31'd0, busy}, 32'd0);
                    $display("done: result=0x%08h error=%b at negedge %0d", result, error, neg_cnt);
                end
            end
        end
    end

    task automatic push_exp(input logic [31:0] res, input logic [1:0] err, input int delay);
        exp_t e;
        e.res = res;
        e.err = err;
        e.neg = snap + delay;
        q.push_back(e);
    endtask

    // Entered #1 after a clock edge; the strobe is sampled 'gap' edges later.
    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap - 1) begin
            @(posedge clock);
            #1;
        end
        rx_DV   = 1'b1;
        rx_Byte = b;
        @(posedge clock);
        snap = neg_cnt;
        #1;
        rx_DV = 1'b0;
    endtask

    task automatic do_start(input logic [7:0] a, input logic with_dv, input logic [7:0] b);
        start    = 1'b1;
        exp_addr = a;
        rx_DV    = with_dv;
        rx_Byte  = b;
        @(posedge clock);
        snap = neg_cnt;
        #1;
        start = 1'b0;
        rx_DV = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h01, {8'h46, 8'h2B, 8'h1A, 8'h01}, 3, 32'h011A2B46, 2'b00};
        vecs[1] = '{8'h01, {8'h46, 8'h2B, 8'h1A, 8'h02}, 0, 32'h00000000, 2'b10};
        vecs[2] = '{8'h01, {8'h47, 8'h2B, 8'h1A, 8'h01}, 3, 32'h00000000, 2'b11};
        vecs[3] = '{8'h01, {8'h02, 8'h02, 8'hFF, 8'h01}, 3, 32'h01FF0202, 2'b00};
        vecs[4] = '{8'hA5, {8'hA5, 8'h00, 8'h00, 8'hA5}, 3, 32'hA50000A5, 2'b00};
        vecs[5] = '{8'hFF, {8'hFD, 8'hFF, 8'hFF, 8'hFF}, 3, 32'hFFFFFFFD, 2'b00};

        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_error", {30'd0, error}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            $display("frame %0d: exp_addr=0x%02h bytes=%08h", i, vecs[i].ea, vecs[i].b);
            do_start(vecs[i].ea, 1'b0, 8'h00);
            idle(2);
            check("busy_after_start", {31'd0, busy}, 32'd1);
            for (int k = 0; k < 4; k++) begin
                send_byte(vecs[i].b[k], 20);
                if (k == vecs[i].trig) push_exp(vecs[i].res, vecs[i].err, 1);
            end
            idle(10);
            check("result_hold", result, vecs[i].res);
        end

        $display("seq: timeout after data_hi");
        do_start(8'h01, 1'b0, 8'h00);
        send_byte(8'h01, 20);
        send_byte(8'h1A, 20);
        push_exp(32'h0, 2'b01, T);
        idle(T + 20);

        $display("seq: timeout straight after start");
        do_start(8'h33, 1'b0, 8'h00);
        push_exp(32'h0, 2'b01, T);
        idle(T + 20);

        $display("seq: byte in expiry cycle");
        do_start(8'h01, 1'b0, 8'h00);
        send_byte(8'h01, 20);
        send_byte(8'h1A, T - 1);
        send_byte(8'h2B, 20);
        send_byte(8'h46, 20);
        push_exp(32'h011A2B46, 2'b00, 1);
        idle(10);

        $display("seq: reset mid-frame");
        do_start(8'h01, 1'b0, 8'h00);
        send_byte(8'h01, 20);
        send_byte(8'h1A, 20);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_done", {31'd0, done}, 32'd0);
        check("rst_mid_result", result, 32'd0);
        check("rst_mid_error", {30'd0, error}, 32'd0);
        send_byte(8'h2B, 20);
        send_byte(8'h46, 20);
        idle(T + 10);
        do_start(8'h01, 1'b0, 8'h00);
        send_byte(8'h01, 20);
        send_byte(8'h1A, 20);
        send_byte(8'h2B, 20);
        send_byte(8'h46, 20);
        push_exp(32'h011A2B46, 2'b00, 1);
        idle(10);

        $display("seq: start while busy");
        do_start(8'h01, 1'b0, 8'h00);
        idle(3);
        do_start(8'h05, 1'b0, 8'h00);
        send_byte(8'h01, 20);
        send_byte(8'h1A, 20);
        do_start(8'h05, 1'b0, 8'h00);
        send_byte(8'h2B, 20);
        send_byte(8'h46, 20);
        push_exp(32'h011A2B46, 2'b00, 1);
        idle(10);

        $display("seq: start with rx_DV in idle");
        do_start(8'h01, 1'b1, 8'h77);
        send_byte(8'h01, 20);
        send_byte(8'h1A, 20);
        send_byte(8'h2B, 20);
        send_byte(8'h46, 20);
        push_exp(32'h011A2B46, 2'b00, 1);

        $display("seq: back-to-back start after FIN");
        idle(1);
        do_start(8'h10, 1'b0, 8'h00);
        send_byte(8'h10, 5);
        send_byte(8'h20, 5);
        send_byte(8'h30, 5);
        send_byte(8'h60, 5);
        push_exp(32'h10203060, 2'b00, 1);
        idle(10);

        check("scoreboard_drained", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
